// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Build option: PIPE_FWD_EN enables E-stage operand forwarding.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    ERR   = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

  // x0 is hard-wired to zero, so a match against it is never a dependency
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != REG_X0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_fwd_sel.sv
// Forwarding select for one E-stage source register; M has priority over W.
// Only present when built with PIPE_FWD_EN.
`ifdef PIPE_FWD_EN
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && reg_match(rd_m, rs)) begin
      sel = FWD_M;
    end else if (reg_write_w && reg_match(rd_w, rs)) begin
      sel = FWD_W;
    end
  end

endmodule
`endif

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hold/flush control: hazards, branch flushes, bounded memory wait, stall counter.
// Build option: PIPE_FWD_EN (forwarding from M/W; only load-use then stalls D).
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic             reg_write_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             load_e,
  input  logic             pc_src_e,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_ctr_q, wait_ctr_d;
  logic                mem_err_q, mem_err_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic                load_use;
  logic                hazard;
  logic [1:0]          fwd_a_raw;
  logic [1:0]          fwd_b_raw;

  assign load_use = load_e && (reg_match(rd_e, rs1_d) || reg_match(rd_e, rs2_d));

`ifdef PIPE_FWD_EN
  assign hazard = load_use;

  fwd_sel u_fwd_a (
    .rs          (rs1_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .sel         (fwd_a_raw)
  );

  fwd_sel u_fwd_b (
    .rs          (rs2_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .sel         (fwd_b_raw)
  );
`else
  logic hit_rs1_d;
  logic hit_rs2_d;
  logic unused_fwd_inputs;

  // W is not checked: the regfile writes in the first half-cycle
  assign hit_rs1_d = (reg_write_e && reg_match(rd_e, rs1_d)) ||
                     (reg_write_m && reg_match(rd_m, rs1_d));
  assign hit_rs2_d = (reg_write_e && reg_match(rd_e, rs2_d)) ||
                     (reg_write_m && reg_match(rd_m, rs2_d));
  assign hazard    = load_use || hit_rs1_d || hit_rs2_d;

  assign fwd_a_raw = FWD_RF;
  assign fwd_b_raw = FWD_RF;
  assign unused_fwd_inputs = ^{rs1_e, rs2_e, rd_w, reg_write_w};
`endif

  always_comb begin
    state_d    = state_q;
    wait_ctr_d = wait_ctr_q;
    mem_err_d  = mem_err_q;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_w    = 1'b0;
    fwd_a_e    = fwd_a_raw;
    fwd_b_e    = fwd_b_raw;

    unique case (state_q)
      RUN: begin
        if (mem_req_m && !mem_ready) begin
          {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
          state_d    = MWAIT;
          wait_ctr_d = WAIT_W'(1);
        end else if (pc_src_e) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (hazard) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      // E is frozen while waiting, so a taken branch there is resolved after release
      MWAIT: begin
        {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
        if (mem_ready) begin
          state_d    = RUN;
          wait_ctr_d = '0;
        end else if (wait_ctr_q == WAIT_LAST) begin
          state_d   = ERR;
          mem_err_d = 1'b1;
        end else begin
          wait_ctr_d = wait_ctr_q + WAIT_W'(1);
        end
      end
      ERR: begin
        {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
        mem_err_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (rst) begin
      {stall_f, stall_d, stall_e, stall_m} = 4'b0000;
      {flush_d, flush_e, flush_w}          = 3'b000;
      fwd_a_e = FWD_RF;
      fwd_b_e = FWD_RF;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_f && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_ctr_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_ctr_q  <= wait_ctr_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl with MAX_WAIT=4; forwarding expectations follow PIPE_FWD_EN.
`timescale 1ns/1ps
module tb_pipe_stall_ctrl;

  typedef struct {
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       we_e, we_m, we_w, load_e, pc_src_e, mem_req_m, mem_ready;
  } stim_t;

  typedef struct {
    string       tag;
    logic [6:0]  ctl;
    logic [3:0]  fwd;
    logic        chk_state;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic        reg_write_e, reg_write_m, reg_write_w;
  logic        load_e, pc_src_e, mem_req_m, mem_ready;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_w;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        mem_err;
  logic [31:0] stall_cnt;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb_q[$];
  exp_t        cur;
  logic [31:0] exp_cnt = 0;
  logic        fwd_on;

`ifdef PIPE_FWD_EN
  initial fwd_on = 1'b1;
`else
  initial fwd_on = 1'b0;
`endif

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MAX_WAIT(4), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rs1_e       (rs1_e),
    .rs2_e       (rs2_e),
    .rd_e        (rd_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_e (reg_write_e),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .load_e      (load_e),
    .pc_src_e    (pc_src_e),
    .mem_req_m   (mem_req_m),
    .mem_ready   (mem_ready),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .stall_e     (stall_e),
    .stall_m     (stall_m),
    .flush_d     (flush_d),
    .flush_e     (flush_e),
    .flush_w     (flush_w),
    .fwd_a_e     (fwd_a_e),
    .fwd_b_e     (fwd_b_e),
    .mem_err     (mem_err),
    .stall_cnt   (stall_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0;
    s.rs1_d = '0; s.rs2_d = '0; s.rs1_e = '0; s.rs2_e = '0;
    s.rd_e = '0; s.rd_m = '0; s.rd_w = '0;
    s.we_e = 1'b0; s.we_m = 1'b0; s.we_w = 1'b0;
    s.load_e = 1'b0; s.pc_src_e = 1'b0; s.mem_req_m = 1'b0; s.mem_ready = 1'b0;
    return s;
  endfunction

  // ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}, fwd = {fwd_a_e, fwd_b_e}
  task automatic applyStimulus(input string tag, input stim_t s, input logic [6:0] ctl,
                               input logic [3:0] fwd, input logic err);
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst;
    rs1_d = s.rs1_d; rs2_d = s.rs2_d; rs1_e = s.rs1_e; rs2_e = s.rs2_e;
    rd_e = s.rd_e; rd_m = s.rd_m; rd_w = s.rd_w;
    reg_write_e = s.we_e; reg_write_m = s.we_m; reg_write_w = s.we_w;
    load_e = s.load_e; pc_src_e = s.pc_src_e;
    mem_req_m = s.mem_req_m; mem_ready = s.mem_ready;
    e.tag = tag; e.ctl = ctl; e.fwd = fwd; e.err = err;
    e.chk_state = !s.rst; e.cnt = exp_cnt;
    sb_q.push_back(e);
    if (s.rst) exp_cnt = 0;
    else if (ctl[6]) exp_cnt = exp_cnt + 1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      checkOutput({cur.tag, "/ctl"},
                  {25'd0, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w},
                  {25'd0, cur.ctl});
      checkOutput({cur.tag, "/fwd"}, {28'd0, fwd_a_e, fwd_b_e}, {28'd0, cur.fwd});
      if (cur.chk_state) begin
        checkOutput({cur.tag, "/err"}, {31'd0, mem_err}, {31'd0, cur.err});
        checkOutput({cur.tag, "/cnt"}, stall_cnt, cur.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    rst = 1'b1;
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    load_e = 0; pc_src_e = 0; mem_req_m = 0; mem_ready = 0;
    repeat (2) @(posedge clk);

    // reset gates everything even with every hazard source active
    s = idle(); s.rst = 1; s.mem_req_m = 1; s.load_e = 1; s.rd_e = 5; s.we_e = 1; s.rs1_d = 5;
    s.pc_src_e = 1; s.rs1_e = 3; s.rd_m = 3; s.we_m = 1;
    applyStimulus("rst_gate", s, 7'b0000000, 4'b0000, 0);
    applyStimulus("idle", idle(), 7'b0000000, 4'b0000, 0);

    s = idle(); s.load_e = 1; s.rd_e = 5; s.we_e = 1; s.rs1_d = 5;
    applyStimulus("load_use", s, 7'b1100010, 4'b0000, 0);
    s = idle(); s.rd_m = 5; s.we_m = 1; s.rs1_d = 5;
    applyStimulus("load_in_m", s, fwd_on ? 7'b0000000 : 7'b1100010, 4'b0000, 0);

    s = idle(); s.pc_src_e = 1; s.load_e = 1; s.rd_e = 7; s.we_e = 1; s.rs1_d = 7;
    applyStimulus("branch_wins", s, 7'b0000110, 4'b0000, 0);

    s = idle(); s.we_m = 1; s.rd_m = 9; s.rs2_d = 9;
    applyStimulus("raw_m_rs2", s, fwd_on ? 7'b0000000 : 7'b1100010, 4'b0000, 0);
    s.rs2_d = 0;
    applyStimulus("raw_x0", s, 7'b0000000, 4'b0000, 0);

    s = idle(); s.rs1_e = 3; s.rd_m = 3; s.rd_w = 3; s.we_m = 1; s.we_w = 1;
    applyStimulus("fwd_m_prio", s, 7'b0000000, fwd_on ? 4'b1000 : 4'b0000, 0);
    s.we_m = 0;
    applyStimulus("fwd_w", s, 7'b0000000, fwd_on ? 4'b0100 : 4'b0000, 0);
    s = idle(); s.we_m = 1; s.we_w = 1;
    applyStimulus("fwd_x0", s, 7'b0000000, 4'b0000, 0);
    s = idle(); s.rs1_e = 4; s.rs2_e = 3; s.rd_m = 4; s.we_m = 1; s.rd_w = 3; s.we_w = 1;
    applyStimulus("fwd_both", s, 7'b0000000, fwd_on ? 4'b1001 : 4'b0000, 0);

    // three not-ready cycles then ready: four stall cycles
    s = idle(); s.mem_req_m = 1;
    applyStimulus("mw_run", s, 7'b1111001, 4'b0000, 0);
    applyStimulus("mw_wait1", s, 7'b1111001, 4'b0000, 0);
    s.pc_src_e = 1;
    applyStimulus("mw_wait2_br", s, 7'b1111001, 4'b0000, 0);
    s.pc_src_e = 0; s.mem_ready = 1;
    applyStimulus("mw_ready", s, 7'b1111001, 4'b0000, 0);
    applyStimulus("mw_released", s, 7'b0000000, 4'b0000, 0);

    s = idle(); s.mem_req_m = 1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("to_wait%0d", i), s, 7'b1111001, 4'b0000, 0);
    end
    applyStimulus("err_hold", s, 7'b1111001, 4'b0000, 1);
    s.mem_ready = 1;
    applyStimulus("err_sticky", s, 7'b1111001, 4'b0000, 1);
    s = idle(); s.rst = 1; s.mem_req_m = 1;
    applyStimulus("err_rst", s, 7'b0000000, 4'b0000, 0);
    applyStimulus("post_rst", idle(), 7'b0000000, 4'b0000, 0);

    s = idle(); s.load_e = 1; s.rd_e = 6; s.rs2_d = 6;
    applyStimulus("load_use_rs2", s, 7'b1100010, 4'b0000, 0);
    applyStimulus("final_idle", idle(), 7'b0000000, 4'b0000, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("sb_drain", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
